spi_arb_seq: RTL and testbench

- Sequencer/arbiter that shares one 16-bit SPI master between two requesters (A, B).
- Per frame: grants one requester, latches its word and bit order, issues a 1-cycle start pulse, tracks the master's busy flag, captures the received word and returns it with a done pulse.
- Round-robin arbitration, programmable inter-frame gap, watchdog timeouts.
- Sits between the system logic and the SPI master (ST/TX_MD/LEFT in; EN_TX/RX_SD out), all on the 50 MHz clk.

---
 rtl/spi_arb_seq.sv | 183 ++++++++++++++++++
 tb/tb_spi_arb_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arb_seq.sv
// spi_arb_seq: round-robin sequencer that shares one 16-bit SPI master between
// requesters A and B. It handles grant, start pulse, busy tracking, receive capture and watchdogs.
module spi_arb_seq #(
    parameter int GAP_CLKS  = 4,
    parameter int TMO_START = 8,
    parameter int TMO_XFER  = 2048,
    parameter int CW        = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic [15:0] tx_a,
    input  logic        left_a,
    input  logic        req_b,
    input  logic [15:0] tx_b,
    input  logic        left_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        done_a,
    output logic        done_b,
    output logic        err,
    output logic        err_src,
    output logic [15:0] rx_dat,
    output logic        spi_st,
    output logic [15:0] spi_tx,
    output logic        spi_left,
    input  logic        spi_en_tx,
    input  logic [15:0] spi_rx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    localparam logic [CW-1:0] START_LAST = CW'(TMO_START - 1);
    localparam logic [CW-1:0] XFER_LAST  = CW'(TMO_XFER - 1);
    localparam logic [CW-1:0] CNT_MAX    = '1;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic          owner, owner_nxt;   // 0 = A, 1 = B
    logic          last, last_nxt;     // most recent winner, used for tie-breaks
    logic          pick_a, pick_b, win;
    logic          start_tmo, xfer_end, xfer_tmo, gap_end;

    logic          gnt_a_nxt, gnt_b_nxt, done_a_nxt, done_b_nxt;
    logic          err_nxt, err_src_nxt, spi_st_nxt, spi_left_nxt;
    logic [15:0]   rx_dat_nxt, spi_tx_nxt;

    // A wins a tie only when B won last; B wins whenever it requests and A does not win.
    assign pick_a    = req_a && (!req_b || last);
    assign pick_b    = req_b && !pick_a;
    // A busy flag left over from an abandoned frame blocks arbitration until it clears.
    assign win       = (state == S_IDLE) && !spi_en_tx && (req_a || req_b);
    assign start_tmo = (state == S_WAIT_BUSY) && !spi_en_tx && (cnt == START_LAST);
    assign xfer_end  = (state == S_WAIT_DONE) && !spi_en_tx;
    assign xfer_tmo  = (state == S_WAIT_DONE) && spi_en_tx && (cnt == XFER_LAST);
    assign gap_end   = (state == S_GAP) && ((int'(cnt) + 1) >= GAP_CLKS);
    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    // State register, with every output registered alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            owner    <= 1'b0;
            last     <= 1'b1;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            done_a   <= 1'b0;
            done_b   <= 1'b0;
            err      <= 1'b0;
            err_src  <= 1'b0;
            rx_dat   <= '0;
            spi_st   <= 1'b0;
            spi_tx   <= '0;
            spi_left <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            owner    <= owner_nxt;
            last     <= last_nxt;
            gnt_a    <= gnt_a_nxt;
            gnt_b    <= gnt_b_nxt;
            done_a   <= done_a_nxt;
            done_b   <= done_b_nxt;
            err      <= err_nxt;
            err_src  <= err_src_nxt;
            rx_dat   <= rx_dat_nxt;
            spi_st   <= spi_st_nxt;
            spi_tx   <= spi_tx_nxt;
            spi_left <= spi_left_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: defaults first, so every path assigns every signal and no latch is inferred.
        state_nxt = state;
        cnt_nxt   = cnt;
        owner_nxt = owner;
        last_nxt  = last;
        case (state)
            S_IDLE: begin
                if (win) begin
                    state_nxt = S_START;
                    owner_nxt = pick_b;
                    last_nxt  = pick_b;
                end
            end
            S_START: begin
                state_nxt = S_WAIT_BUSY;
                cnt_nxt   = '0;
            end
            S_WAIT_BUSY: begin
                if (spi_en_tx) begin
                    state_nxt = S_WAIT_DONE;
                    cnt_nxt   = '0;
                end else if (start_tmo) begin
                    state_nxt = S_GAP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            S_WAIT_DONE: begin
                if (xfer_end || xfer_tmo) begin
                    state_nxt = S_GAP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            S_GAP: begin
                if (gap_end) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        gnt_a_nxt    = gnt_a;
        gnt_b_nxt    = gnt_b;
        done_a_nxt   = 1'b0;
        done_b_nxt   = 1'b0;
        err_nxt      = 1'b0;
        err_src_nxt  = err_src;
        spi_st_nxt   = 1'b0;
        rx_dat_nxt   = rx_dat;
        spi_tx_nxt   = spi_tx;
        spi_left_nxt = spi_left;
        if (win) begin
            gnt_a_nxt    = pick_a;
            gnt_b_nxt    = pick_b;
            spi_st_nxt   = 1'b1;
            spi_tx_nxt   = pick_a ? tx_a : tx_b;
            spi_left_nxt = pick_a ? left_a : left_b;
        end else if (xfer_end) begin
            gnt_a_nxt  = 1'b0;
            gnt_b_nxt  = 1'b0;
            rx_dat_nxt = spi_rx;
            done_a_nxt = !owner;
            done_b_nxt = owner;
        end else if (start_tmo || xfer_tmo) begin
            gnt_a_nxt   = 1'b0;
            gnt_b_nxt   = 1'b0;
            err_nxt     = 1'b1;
            err_src_nxt = owner;
        end
    end

endmodule

// File: tb/tb_spi_arb_seq.sv
// Directed bench for spi_arb_seq: default instance plus a GAP_CLKS=0 instance,
// with a behavioural SPI master that can respond, never go busy, or stick busy.
`timescale 1ns/1ps
module tb_spi_arb_seq;

    localparam int BUSY_CLKS = 32;   // 16 SCLK periods at clk/2

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, left_a, req_b, left_b;
    logic [15:0] tx_a, tx_b;
    logic        gnt_a, gnt_b, done_a, done_b, err, err_src, spi_st, spi_left;
    logic [15:0] rx_dat, spi_tx;
    logic        spi_en_tx;
    logic [15:0] spi_rx;

    logic        model_en, model_block, stuck_en;
    logic [15:0] model_dat;

    logic        req_b0, en0;
    logic [15:0] rx0;
    logic        gnt_a0, gnt_b0, done_a0, done_b0, err0, err_src0, spi_st0, spi_left0;
    logic [15:0] rx_dat0, spi_tx0;

    int tests = 0;
    int fails = 0;

    assign spi_en_tx = model_en | stuck_en;
    assign spi_rx    = stuck_en ? 16'h1111 : model_dat;

    always #10 clk = ~clk;

    spi_arb_seq u_dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .tx_a(tx_a), .left_a(left_a),
        .req_b(req_b), .tx_b(tx_b), .left_b(left_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .err(err), .err_src(err_src), .rx_dat(rx_dat),
        .spi_st(spi_st), .spi_tx(spi_tx), .spi_left(spi_left),
        .spi_en_tx(spi_en_tx), .spi_rx(spi_rx)
    );

    spi_arb_seq #(.GAP_CLKS(0)) u_gap0 (
        .clk(clk), .rst(rst),
        .req_a(1'b0), .tx_a(16'h0000), .left_a(1'b0),
        .req_b(req_b0), .tx_b(16'hC33C), .left_b(1'b0),
        .gnt_a(gnt_a0), .gnt_b(gnt_b0), .done_a(done_a0), .done_b(done_b0),
        .err(err0), .err_src(err_src0), .rx_dat(rx_dat0),
        .spi_st(spi_st0), .spi_tx(spi_tx0), .spi_left(spi_left0),
        .spi_en_tx(en0), .spi_rx(rx0)
    );

    // Behavioural master: goes busy on a start pulse, returns A5C3 when it finishes.
    initial begin
        model_en  = 1'b0;
        model_dat = 16'h0000;
        forever begin
            @(negedge clk);
            if (spi_st === 1'b1 && !model_block) begin
                model_en  = 1'b1;
                model_dat = 16'h0000;
                repeat (BUSY_CLKS) @(negedge clk);
                model_en  = 1'b0;
                model_dat = 16'hA5C3;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, finish required");
        $fatal(1, "global timeout");
    end

    // sel: 0 spi_st, 1 any done, 2 err, 3 gnt_b0, 4 done_b0
    task automatic wait_sig(input int sel, input int limit, input string name, output int n);
        bit hit;
        hit = 1'b0;
        n   = 0;
        while (!hit && n < limit) begin
            @(negedge clk);
            n++;
            case (sel)
                0:       hit = spi_st;
                1:       hit = done_a | done_b;
                2:       hit = err;
                3:       hit = gnt_b0;
                default: hit = done_b0;
            endcase
        end
        if (!hit) begin
            tests++;
            fails++;
            $display("FAIL %s: no event within %0d clocks, event required", name, limit);
        end
    endtask

    task automatic test_reset();
        logic [39:0] obs;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        obs = {gnt_a, gnt_b, done_a, done_b, err, err_src, spi_st, spi_left, spi_tx, rx_dat};
        tests++;
        if (obs !== 40'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h, expected %h", obs, 40'h0);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_a();
        int n;
        logic [35:0] obs, exp;
        req_a = 1'b1; tx_a = 16'h000F; left_a = 1'b0;
        @(negedge clk);
        obs = {16'h0, gnt_a, gnt_b, spi_st, spi_left, spi_tx};
        exp = {16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h000F};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL single_grant: got %h, expected %h", obs, exp);
        end
        tx_a = 16'h1234;
        @(negedge clk);
        tests++;
        if (spi_st !== 1'b0) begin
            fails++;
            $display("FAIL single_st_pulse: got %b, expected 0", spi_st);
        end
        wait_sig(1, 100, "single_done_wait", n);
        tests++;
        if (n !== 32) begin
            fails++;
            $display("FAIL single_done_latency: got %0d, expected 32", n);
        end
        obs = {done_a, done_b, gnt_a, err, rx_dat, spi_tx};
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 16'hA5C3, 16'h000F};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL single_done: got %h, expected %h", obs, exp);
        end
        req_a = 1'b0;
        @(negedge clk);
        tests++;
        if (done_a !== 1'b0) begin
            fails++;
            $display("FAIL single_done_pulse: got %b, expected 0", done_a);
        end
    endtask

    task automatic test_contention();
        int n;
        logic eb;
        logic [18:0] obs, exp;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tx_a = 16'h000F; left_a = 1'b0; tx_b = 16'hF0F0; left_b = 1'b1;
        req_a = 1'b1; req_b = 1'b1;
        for (int f = 0; f < 4; f++) begin
            eb = f[0];
            wait_sig(0, 50, "cont_start_wait", n);
            if (f > 0) begin
                tests++;
                if (n !== 5) begin
                    fails++;
                    $display("FAIL cont_gap%0d: got %0d clocks done->start, expected 5", f, n);
                end
            end
            obs = {gnt_a, gnt_b, spi_left, spi_tx};
            exp = {!eb, eb, eb, eb ? 16'hF0F0 : 16'h000F};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL cont_grant%0d: got %h, expected %h", f, obs, exp);
            end
            wait_sig(1, 100, "cont_done_wait", n);
            tests++;
            if ({done_a, done_b} !== {!eb, eb}) begin
                fails++;
                $display("FAIL cont_done%0d: got %b, expected %b", f, {done_a, done_b}, {!eb, eb});
            end
            if (f == 3) begin
                req_a = 1'b0;
                req_b = 1'b0;
            end
        end
    endtask

    task automatic test_start_timeout();
        int n;
        model_block = 1'b1;
        req_a = 1'b1;
        wait_sig(0, 50, "stmo_start_wait", n);
        wait_sig(2, 30, "stmo_err_wait", n);
        tests++;
        if (n !== 9) begin
            fails++;
            $display("FAIL stmo_latency: got %0d clocks after start, expected 9", n);
        end
        tests++;
        if ({err_src, done_a, done_b, gnt_a} !== 4'b0000) begin
            fails++;
            $display("FAIL stmo_err: got src/done_a/done_b/gnt_a %b, expected 0000",
                     {err_src, done_a, done_b, gnt_a});
        end
        req_a = 1'b0;
        req_b = 1'b1;
        model_block = 1'b0;
        wait_sig(0, 50, "stmo_next_wait", n);
        tests++;
        if (n !== 5 || gnt_b !== 1'b1) begin
            fails++;
            $display("FAIL stmo_next_grant: got %0d clocks gnt_b=%b, expected 5 clocks gnt_b=1", n, gnt_b);
        end
        wait_sig(1, 100, "stmo_next_done", n);
        tests++;
        if (done_b !== 1'b1) begin
            fails++;
            $display("FAIL stmo_next_done: got %b, expected 1", done_b);
        end
        req_b = 1'b0;
    endtask

    task automatic test_xfer_timeout();
        int n;
        model_block = 1'b1;
        req_b = 1'b1;
        wait_sig(0, 50, "xtmo_start_wait", n);
        stuck_en = 1'b1;
        wait_sig(2, 2100, "xtmo_err_wait", n);
        tests++;
        if (n !== 2050) begin
            fails++;
            $display("FAIL xtmo_latency: got %0d clocks after start, expected 2050", n);
        end
        tests++;
        if ({err_src, done_b, gnt_b, rx_dat} !== {3'b100, 16'hA5C3}) begin
            fails++;
            $display("FAIL xtmo_err: got %h, expected %h", {err_src, done_b, gnt_b, rx_dat},
                     {3'b100, 16'hA5C3});
        end
        req_b = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int n;
        bit bad;
        logic [39:0] obs;
        stuck_en = 1'b0;
        model_block = 1'b0;
        req_a = 1'b1;
        wait_sig(0, 50, "rmid_start_wait", n);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        stuck_en = 1'b1;
        @(negedge clk);
        obs = {gnt_a, gnt_b, done_a, done_b, err, err_src, spi_st, spi_left, spi_tx, rx_dat};
        tests++;
        if (obs !== 40'h0) begin
            fails++;
            $display("FAIL rmid_outputs: got %h, expected %h", obs, 40'h0);
        end
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt_a | done_a | spi_st | err) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL rmid_blocked: got activity while busy high, expected none");
        end
        stuck_en = 1'b0;
        @(negedge clk);
        tests++;
        if ({gnt_a, spi_st} !== 2'b11) begin
            fails++;
            $display("FAIL rmid_regrant: got gnt_a/spi_st %b, expected 11", {gnt_a, spi_st});
        end
        wait_sig(1, 100, "rmid_done_wait", n);
        tests++;
        if ({done_a, rx_dat} !== {1'b1, 16'hA5C3}) begin
            fails++;
            $display("FAIL rmid_done: got %h, expected %h", {done_a, rx_dat}, {1'b1, 16'hA5C3});
        end
        req_a = 1'b0;
    endtask

    task automatic test_gap0_back_to_back();
        int n;
        req_b0 = 1'b1;
        wait_sig(3, 20, "gap0_grant_wait", n);
        tests++;
        if ({spi_st0, spi_tx0} !== {1'b1, 16'hC33C}) begin
            fails++;
            $display("FAIL gap0_start: got %h, expected %h", {spi_st0, spi_tx0}, {1'b1, 16'hC33C});
        end
        en0 = 1'b1;
        repeat (3) @(negedge clk);
        en0 = 1'b0;
        rx0 = 16'h5A5A;
        wait_sig(4, 20, "gap0_done_wait", n);
        tests++;
        if ({gnt_b0, rx_dat0} !== {1'b0, 16'h5A5A}) begin
            fails++;
            $display("FAIL gap0_done: got %h, expected %h", {gnt_b0, rx_dat0}, {1'b0, 16'h5A5A});
        end
        @(negedge clk);
        tests++;
        if (gnt_b0 !== 1'b0) begin
            fails++;
            $display("FAIL gap0_idle: got gnt_b0 %b, expected 0", gnt_b0);
        end
        @(negedge clk);
        tests++;
        if ({gnt_b0, spi_st0} !== 2'b11) begin
            fails++;
            $display("FAIL gap0_regrant: got %b, expected 11", {gnt_b0, spi_st0});
        end
        req_b0 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_a = 1'b0; tx_a = 16'h0; left_a = 1'b0;
        req_b = 1'b0; tx_b = 16'h0; left_b = 1'b0;
        model_block = 1'b0; stuck_en = 1'b0;
        req_b0 = 1'b0; en0 = 1'b0; rx0 = 16'h0;
        test_reset();
        test_single_a();
        test_contention();
        test_start_timeout();
        test_xfer_timeout();
        test_reset_mid_frame();
        test_gap0_back_to_back();
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
